// File: rtl/mem_burst_model.sv
// Line-granular main-memory model: whole-line READ/WRITE bursts, one beat per clock,
// programmable access latency, registered response/data/busy outputs.
module mem_burst_model #(
    parameter int ADDR_WIDTH = 15,
    parameter int BUS_WIDTH  = 16,
    parameter int LINE_BYTES = 16,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            cmd_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [BUS_WIDTH-1:0]  wdata,
    output logic [1:0]            cmd_out,
    output logic [BUS_WIDTH-1:0]  rdata,
    output logic                  busy
);
    localparam int LINE_BITS = LINE_BYTES * 8;
    localparam int BEATS     = LINE_BITS / BUS_WIDTH;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAT_W     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int EPOCH_W   = 16;
    localparam int SUM_W     = ADDR_WIDTH + 32;

    localparam logic [1:0] CMD_NOP   = 2'd0;
    localparam logic [1:0] CMD_RESP  = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_WRITE = 2'd3;

    generate
        if (BEATS < 2 || (LINE_BITS % BUS_WIDTH) != 0) begin : g_bad_geometry
            $error("mem_burst_model: LINE_BYTES*8/BUS_WIDTH must be an integer >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, WR_BEATS, WAIT, RD_BEATS, WR_ACK} state_t;

    state_t                state_reg, state_next;
    logic [BEAT_W-1:0]     beat_cnt_reg, beat_cnt_next;
    logic [LAT_W-1:0]      lat_cnt_reg, lat_cnt_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  is_write_reg;
    logic [EPOCH_W-1:0]    epoch_reg;
    logic [1:0]            cmd_out_reg, cmd_out_next;
    logic [BUS_WIDTH-1:0]  rdata_reg, rdata_next;
    logic                  busy_reg, busy_next;
    logic                  accept, rd_accept, wr_capture, commit;
    logic [BEAT_W-1:0]     wr_idx;

    // Each stored line carries the epoch in which it was written; bumping the epoch on
    // reset makes every line read back as its init pattern without sweeping the array.
    logic [LINE_BITS-1:0]  mem_data [DEPTH];
    logic [EPOCH_W-1:0]    mem_tag  [DEPTH];
    logic [LINE_BITS-1:0]  rd_line_reg;
    logic [EPOCH_W-1:0]    rd_tag_reg;
    logic [BUS_WIDTH-1:0]  wr_beats_reg [BEATS];
    logic [LINE_BITS-1:0]  wr_line;
    logic [BUS_WIDTH-1:0]  rd_beats [BEATS];
    logic [BUS_WIDTH-1:0]  rd_beat, init_beat;

    // busy_reg also covers the final response cycle, when state has already returned to IDLE.
    assign accept     = (state_reg == IDLE) && !busy_reg && !reset;
    assign rd_accept  = accept && (cmd_in == CMD_READ);
    assign wr_capture = (accept && (cmd_in == CMD_WRITE)) || (state_reg == WR_BEATS);
    assign wr_idx     = (state_reg == WR_BEATS) ? beat_cnt_reg : '0;

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
            assign rd_beats[gi] = rd_line_reg[gi*BUS_WIDTH +: BUS_WIDTH];
            if (gi == BEATS - 1) begin : g_last
                // With zero latency the commit edge is also the edge that samples the last beat.
                assign wr_line[gi*BUS_WIDTH +: BUS_WIDTH] =
                    (state_reg == WR_BEATS) ? wdata : wr_beats_reg[gi];
            end else begin : g_mid
                assign wr_line[gi*BUS_WIDTH +: BUS_WIDTH] = wr_beats_reg[gi];
            end
        end
    endgenerate

    assign rd_beat   = rd_beats[beat_cnt_reg];
    assign init_beat = BUS_WIDTH'(SUM_W'(addr_reg) * SUM_W'(BEATS) + SUM_W'(beat_cnt_reg));

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        lat_cnt_next  = lat_cnt_reg;
        commit        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept && cmd_in == CMD_READ) begin
                    beat_cnt_next = '0;
                    if (LATENCY == 0) begin
                        state_next = RD_BEATS;
                    end else begin
                        state_next   = WAIT;
                        lat_cnt_next = LAT_W'(LATENCY);
                    end
                end else if (accept && cmd_in == CMD_WRITE) begin
                    state_next    = WR_BEATS;
                    beat_cnt_next = BEAT_W'(1);
                end
            end
            WR_BEATS: begin
                if (beat_cnt_reg == BEAT_W'(BEATS - 1)) begin
                    if (LATENCY == 0) begin
                        state_next = WR_ACK;
                        commit     = 1'b1;
                    end else begin
                        state_next   = WAIT;
                        lat_cnt_next = LAT_W'(LATENCY);
                    end
                end else begin
                    beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
                end
            end
            WAIT: begin
                if (lat_cnt_reg <= LAT_W'(1)) begin
                    lat_cnt_next = '0;
                    if (is_write_reg) begin
                        state_next = WR_ACK;
                        commit     = 1'b1;
                    end else begin
                        state_next    = RD_BEATS;
                        beat_cnt_next = '0;
                    end
                end else begin
                    lat_cnt_next = lat_cnt_reg - LAT_W'(1);
                end
            end
            RD_BEATS: begin
                if (beat_cnt_reg == BEAT_W'(BEATS - 1)) begin
                    state_next = IDLE;
                end else begin
                    beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
                end
            end
            WR_ACK:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_out_next = CMD_NOP;
        rdata_next   = '0;
        busy_next    = (state_reg != IDLE);
        if (state_reg == RD_BEATS) begin
            cmd_out_next = CMD_RESP;
            rdata_next   = (rd_tag_reg == epoch_reg) ? rd_beat : init_beat;
        end else if (state_reg == WR_ACK) begin
            cmd_out_next = CMD_RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            lat_cnt_reg  <= '0;
            addr_reg     <= '0;
            is_write_reg <= 1'b0;
            cmd_out_reg  <= CMD_NOP;
            rdata_reg    <= '0;
            busy_reg     <= 1'b0;
            epoch_reg    <= (epoch_reg == '1) ? EPOCH_W'(1) : epoch_reg + EPOCH_W'(1);
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            lat_cnt_reg  <= lat_cnt_next;
            cmd_out_reg  <= cmd_out_next;
            rdata_reg    <= rdata_next;
            busy_reg     <= busy_next;
            if (accept && (cmd_in == CMD_READ || cmd_in == CMD_WRITE)) begin
                addr_reg     <= addr_in;
                is_write_reg <= (cmd_in == CMD_WRITE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && !reset) begin
            mem_data[addr_reg] <= wr_line;
            mem_tag[addr_reg]  <= epoch_reg;
        end
        if (rd_accept) begin
            rd_line_reg <= mem_data[addr_in];
            rd_tag_reg  <= mem_tag[addr_in];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_capture) begin
            wr_beats_reg[wr_idx] <= wdata;
        end
    end

    assign cmd_out = cmd_out_reg;
    assign rdata   = rdata_reg;
    assign busy    = busy_reg;
endmodule

// File: tb/tb_mem_burst_model.sv
// Bench for mem_burst_model: default instance driven from a transaction table with a
// response scoreboard, plus a 32-bit / zero-latency instance exercised by hand.
module tb_mem_burst_model;
    localparam int AW    = 15;
    localparam int BW    = 16;
    localparam int BEATS = 8;
    localparam int LAT   = 3;
    localparam logic [1:0] NOP  = 2'd0;
    localparam logic [1:0] RESP = 2'd1;
    localparam logic [1:0] RD   = 2'd2;
    localparam logic [1:0] WR   = 2'd3;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    cmd_in;
    logic [AW-1:0] addr_in;
    logic [BW-1:0] wdata;
    logic [1:0]    cmd_out;
    logic [BW-1:0] rdata;
    logic          busy;

    logic [1:0]    cmd2;
    logic [AW-1:0] addr2;
    logic [31:0]   wdata2;
    logic [1:0]    cmd_out2;
    logic [31:0]   rdata2;
    logic          busy2;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;
    logic mon_en = 1'b0;

    typedef struct {
        int            edge_no;
        logic [BW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [1:0]    cmd;
        logic [1:0]    junk;
        logic [AW-1:0] addr;
        logic [BW-1:0] wbase;
        logic [BW-1:0] ebase;
    } txn_t;
    txn_t tbl [13];

    mem_burst_model #(.ADDR_WIDTH(AW), .BUS_WIDTH(BW), .LINE_BYTES(16), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .cmd_in(cmd_in), .addr_in(addr_in), .wdata(wdata),
        .cmd_out(cmd_out), .rdata(rdata), .busy(busy)
    );

    mem_burst_model #(.ADDR_WIDTH(AW), .BUS_WIDTH(32), .LINE_BYTES(16), .LATENCY(0)) dut2 (
        .clk(clk), .reset(reset), .cmd_in(cmd2), .addr_in(addr2), .wdata(wdata2),
        .cmd_out(cmd_out2), .rdata(rdata2), .busy(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Every response cycle of the default instance must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (cmd_out != NOP) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_resp cyc=%0d got cmd_out=%0d rdata=%h want no response",
                             cyc, cmd_out, rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_cmd", 32'(cmd_out), 32'(RESP));
                    chk("resp_edge", cyc, e.edge_no);
                    chk("resp_data", 32'(rdata), 32'(e.data));
                end
            end else begin
                chk("idle_rdata", 32'(rdata), 32'h0);
            end
        end
    end

    task automatic run_txn(input txn_t t);
        int e0;
        int last;
        bit active;
        active = (t.cmd == RD) || (t.cmd == WR);
        @(negedge clk);
        cmd_in  = t.cmd;
        addr_in = t.addr;
        wdata   = t.wbase;
        e0      = cyc + 1;
        last    = e0;
        if (t.cmd == RD) begin
            for (int k = 0; k < BEATS; k++) exp_q.push_back('{e0 + LAT + 1 + k, t.ebase + BW'(k)});
            last = e0 + LAT + BEATS;
        end else if (t.cmd == WR) begin
            exp_q.push_back('{e0 + BEATS + LAT, '0});
            last = e0 + BEATS + LAT;
        end
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (t.cmd == WR && n < BEATS - 1) begin
                wdata   = t.wbase + BW'(n + 1);
                cmd_in  = t.junk;
                addr_in = 15'h3;
            end else if (cyc <= last) begin
                cmd_in  = t.junk;
                addr_in = t.addr;
                wdata   = 16'hBEEF;
            end else begin
                cmd_in = NOP;
            end
            if (active && cyc == e0 + 1) chk("busy_start", 32'(busy), 32'h1);
            if (active && cyc == last)   chk("busy_last", 32'(busy), 32'h1);
            if (cyc == last + 1) begin
                chk("busy_end", 32'(busy), 32'h0);
                chk("pending", exp_q.size(), 0);
                break;
            end
        end
    endtask

    task automatic d2_read(input logic [AW-1:0] a, input logic [31:0] eb);
        @(negedge clk);
        cmd2  = RD;
        addr2 = a;
        @(negedge clk);
        cmd2 = NOP;
        chk("d2_rd_pre", 32'(cmd_out2), 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("d2_rd_cmd", 32'(cmd_out2), 32'(RESP));
            chk("d2_rd_data", rdata2, eb + 32'(k));
            chk("d2_rd_busy", 32'(busy2), 32'h1);
        end
        @(negedge clk);
        chk("d2_rd_end_cmd", 32'(cmd_out2), 32'h0);
        chk("d2_rd_end_busy", 32'(busy2), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{RD, NOP, 15'h0005, 16'h0000, 16'h0028};
        tbl[1]  = '{WR, RD,  15'h0010, 16'hA000, 16'h0000};
        tbl[2]  = '{RD, NOP, 15'h0010, 16'h0000, 16'hA000};
        tbl[3]  = '{RD, WR,  15'h0002, 16'h0000, 16'h0010};
        tbl[4]  = '{RD, NOP, 15'h0002, 16'h0000, 16'h0010};
        tbl[5]  = '{RD, RD,  15'h7FFF, 16'h0000, 16'hFFF8};
        tbl[6]  = '{RESP, NOP, 15'h0005, 16'h0000, 16'h0000};
        tbl[7]  = '{NOP, NOP, 15'h0000, 16'h0000, 16'h0000};
        tbl[8]  = '{WR, WR,  15'h7FFF, 16'h1234, 16'h0000};
        tbl[9]  = '{RD, NOP, 15'h7FFF, 16'h0000, 16'h1234};
        tbl[10] = '{RD, NOP, 15'h7FFE, 16'h0000, 16'hFFF0};
        tbl[11] = '{WR, NOP, 15'h0000, 16'h0F00, 16'h0000};
        tbl[12] = '{RD, NOP, 15'h0000, 16'h0000, 16'h0F00};

        reset   = 1'b1;
        cmd_in  = NOP;
        addr_in = '0;
        wdata   = '0;
        cmd2    = NOP;
        addr2   = '0;
        wdata2  = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_out", 32'(cmd_out), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_d2_busy", 32'(busy2), 32'h0);
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 13; i++) run_txn(tbl[i]);

        // Reset lands on the third write beat: nothing may be committed or acknowledged.
        begin : reset_mid_write
            @(negedge clk);
            cmd_in  = WR;
            addr_in = 15'h7;
            wdata   = 16'h5500;
            @(negedge clk);
            cmd_in = NOP;
            wdata  = 16'h5501;
            @(negedge clk);
            wdata = 16'h5502;
            reset = 1'b1;
            @(negedge clk);
            chk("rst_mid_cmd_out", 32'(cmd_out), 32'h0);
            chk("rst_mid_rdata", 32'(rdata), 32'h0);
            chk("rst_mid_busy", 32'(busy), 32'h0);
            reset = 1'b0;
            repeat (BEATS + LAT + 4) @(negedge clk);
            chk("rst_mid_busy_later", 32'(busy), 32'h0);
            chk("rst_mid_pending", exp_q.size(), 0);
        end
        run_txn('{RD, NOP, 15'h0007, 16'h0000, 16'h0038});
        run_txn('{RD, NOP, 15'h0010, 16'h0000, 16'h0080});
        run_txn('{RD, NOP, 15'h7FFF, 16'h0000, 16'hFFF8});

        d2_read(15'h3, 32'd12);
        begin : d2_write
            @(negedge clk);
            cmd2   = WR;
            addr2  = 15'h9;
            wdata2 = 32'hC0DE0000;
            for (int k = 1; k < 4; k++) begin
                @(negedge clk);
                cmd2   = NOP;
                wdata2 = 32'hC0DE0000 + 32'(k);
                chk("d2_wr_quiet", 32'(cmd_out2), 32'h0);
            end
            @(negedge clk);
            chk("d2_ack_pre", 32'(cmd_out2), 32'h0);
            @(negedge clk);
            chk("d2_ack_cmd", 32'(cmd_out2), 32'(RESP));
            chk("d2_ack_rdata", rdata2, 32'h0);
            @(negedge clk);
            chk("d2_ack_end_cmd", 32'(cmd_out2), 32'h0);
            chk("d2_ack_end_busy", 32'(busy2), 32'h0);
        end
        d2_read(15'h9, 32'hC0DE0000);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_burst_model.md
Name: mem_burst_model

Overview:
Parametrised line-granular main-memory model for the cache/memory testbench. It serves whole-line READ and WRITE bursts over a narrow data bus, one beat per clock. Unlike the previous memory model, it has:
- configurable access latency and bus width;
- separate read/write data ports;
- an explicit RESPONSE code on a command-out port for reads and write acknowledges;
- a busy indication.

Parameters:
ADDR_WIDTH, 15, line-address width; depth = 2^ADDR_WIDTH lines
BUS_WIDTH, 16, data bits per beat
LINE_BYTES, 16, bytes per line; BEATS = LINE_BYTES*8/BUS_WIDTH, must be an integer >= 2 (elaboration error otherwise)
LATENCY, 3, idle cycles between command completion and first response cycle; 0 allowed

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
cmd_in  in  2  command: 0 NOP, 1 RESPONSE (treated as NOP), 2 READ, 3 WRITE
addr_in  in  ADDR_WIDTH  line address, sampled with the command
wdata  in  BUS_WIDTH  write beat data
cmd_out  out  2  0 NOP, 1 RESPONSE; registered
rdata  out  BUS_WIDTH  read beat data; registered, 0 when not responding
busy  out  1  high from the cycle after accept through the last response cycle; registered

Behaviour:
- Reset (sampled at an edge while reset=1):
  - state->IDLE; cmd_out=0, rdata=0, busy=0; all counters cleared.
  - Every line i is initialised so that beat k = (i*BEATS + k) mod 2^BUS_WIDTH.
  - Reset wins over any command in the same cycle.
  - Reset mid-burst: burst abandoned; an unfinished write is never committed.
- Beat order: beat 0 = line bits [BUS_WIDTH-1:0], ascending.
- States: IDLE, WR_BEATS, WAIT, RD_BEATS, WR_ACK.
- Commands are accepted only at an edge where state=IDLE. In any other state cmd_in/addr_in are ignored, with no side effect.
- Accept edge is called E0.
- READ accepted at E0:
  - addr latched; go to WAIT with counter=LATENCY (LATENCY=0 goes directly to RD_BEATS).
  - Beat k is driven, with cmd_out=1, in the cycle starting at edge E0+LATENCY+1+k, for k=0..BEATS-1.
  - After the last beat: IDLE, cmd_out=0, rdata=0.
  - Data is read from the line contents as of E0.
- WRITE accepted at E0:
  - Beat 0 = wdata at E0; beat k = wdata at edge E0+k (WR_BEATS). cmd_in is don't-care during beats 1..BEATS-1.
  - After the last beat (edge E0+BEATS-1): WAIT for LATENCY cycles.
  - Then WR_ACK: cmd_out=1 for exactly one cycle, starting at edge E0+BEATS+LATENCY. rdata stays 0.
  - The line is committed atomically at the edge that enters WR_ACK. A READ accepted after the ack returns the new data.
- busy: 0 in IDLE, 1 in every other state. A command presented during the final response cycle is ignored; the next accept is possible at the edge after it.
- Counters: a beat counter of width clog2(BEATS) and a latency counter of width clog2(LATENCY+1). Neither counter wraps beyond its terminal value.
- Address: full ADDR_WIDTH range is valid, with no wrap across lines. Init-pattern arithmetic truncates to BUS_WIDTH.

Test Plan:
- Defaults (BEATS=8, LATENCY=3): reset, READ addr 5 at E0 -> cmd_out=1 on edges E0+4..E0+11; rdata 0x0028..0x002F in order; busy=1 from E0+1 through E0+11; all outputs 0 at E0+12.
- WRITE addr 0x10, beats 0xA000..0xA007 on consecutive edges -> single cmd_out=1 cycle at E0+11, rdata=0. A following READ 0x10 -> 0xA000..0xA007.
- READ addr 2 accepted, then WRITE addr 2 issued while busy -> write ignored; returned beats 0x0010..0x0017; a later READ 2 -> same values.
- Reset asserted at edge E0+2 of a WRITE to addr 7 -> outputs 0 next cycle, busy=0; READ 7 returns the init pattern 0x0038..0x003F.
- BUS_WIDTH=32, LATENCY=0 (BEATS=4): READ addr 3 -> beats 12,13,14,15 at edges E0+1..E0+4.
- Defaults, READ addr 0x7FFF -> beats 0xFFF8..0xFFFF (truncation); commands with cmd_in=1 in IDLE -> no response, busy stays 0.
